rename_regfile: RTL and testbench

Parametrised successor to the single-issue architectural register file. Holds committed values V and rename tags Q (ROB id, 0 = not dependent) for all integer registers, and serves DISPATCH_W dispatch slots per cycle (two source lookups plus one destination rename each). It also retires up to COMMIT_W ROB write-backs per cycle and clears all tags on mispredict. It sits between the dispatcher and the ROB and keeps a registered count of busy registers for stall and performance logic.

---
 rtl/rename_regfile_pkg.sv | 12 +
 rtl/rename_lookup.sv | 79 +++++++
 rtl/rename_regfile.sv | 130 +++++++++++++
 tb/tb_rename_regfile.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared defaults and tag constants for the rename register file and its lookup slices.
// Tag value 0 marks a register whose committed value is current.
package rename_regfile_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int REG_NUM_DEF    = 32;
   localparam int TAG_W_DEF      = 4;
   localparam int DISPATCH_W_DEF = 2;
   localparam int COMMIT_W_DEF   = 2;
   localparam int NON_DEPENDENT  = 0;

endpackage

// File: rtl/rename_lookup.sv
// One source-operand lookup: intra-bundle forwarding from older slots, commit bypass,
// then the architectural V/Q pair. SLOT masks out same-or-younger dispatch slots.
module rename_lookup
   import rename_regfile_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_NUM    = REG_NUM_DEF,
   parameter int RS_W       = $clog2(REG_NUM) + 1,
   parameter int RD_W       = $clog2(REG_NUM),
   parameter int TAG_W      = TAG_W_DEF,
   parameter int DISPATCH_W = DISPATCH_W_DEF,
   parameter int COMMIT_W   = COMMIT_W_DEF,
   parameter int SLOT       = 0
)(
   input  logic [RS_W-1:0]            rs,
   input  logic [DISPATCH_W-1:0]      dsp_en,
   input  logic [DISPATCH_W*RD_W-1:0] rd_from_dsp,
   input  logic [DISPATCH_W*TAG_W-1:0] Q_from_dsp,
   input  logic [COMMIT_W-1:0]        rob_en,
   input  logic [COMMIT_W*RD_W-1:0]   rd_from_rob,
   input  logic [COMMIT_W*TAG_W-1:0]  Q_from_rob,
   input  logic [COMMIT_W*XLEN-1:0]   V_from_rob,
   input  logic [TAG_W-1:0]           q_cur,
   input  logic [XLEN-1:0]            v_cur,
   input  logic                       mispredict,
   output logic [XLEN-1:0]            v_out,
   output logic [TAG_W-1:0]           q_out
);

   logic             fwd_hit_s;
   logic [TAG_W-1:0] fwd_q_s;
   logic             byp_hit_s;
   logic [XLEN-1:0]  byp_v_s;

   // Operand resolution; later loop iterations overwrite earlier ones so the highest slot/port wins.
   always_comb begin
      fwd_hit_s = 1'b0;
      fwd_q_s   = TAG_W'(NON_DEPENDENT);
      byp_hit_s = 1'b0;
      byp_v_s   = '0;
      v_out     = '0;
      q_out     = TAG_W'(NON_DEPENDENT);
      for (int e = 0; e < DISPATCH_W; e++) begin
         if ((e < SLOT) && dsp_en[e] && (RS_W'(rd_from_dsp[e*RD_W +: RD_W]) == rs)) begin
            fwd_hit_s = 1'b1;
            fwd_q_s   = Q_from_dsp[e*TAG_W +: TAG_W];
         end else begin
            fwd_hit_s = fwd_hit_s;
         end
      end
      // During a flush the tag comparison is dropped: port order alone picks the value.
      for (int c = 0; c < COMMIT_W; c++) begin
         if (rob_en[c] && (RS_W'(rd_from_rob[c*RD_W +: RD_W]) == rs) &&
             (mispredict || (Q_from_rob[c*TAG_W +: TAG_W] == q_cur))) begin
            byp_hit_s = 1'b1;
            byp_v_s   = V_from_rob[c*XLEN +: XLEN];
         end else begin
            byp_hit_s = byp_hit_s;
         end
      end
      if ((rs == '0) || (rs >= RS_W'(REG_NUM))) begin
         v_out = '0;
         q_out = TAG_W'(NON_DEPENDENT);
      end else if (mispredict) begin
         v_out = byp_hit_s ? byp_v_s : v_cur;
         q_out = TAG_W'(NON_DEPENDENT);
      end else if (fwd_hit_s) begin
         v_out = '0;
         q_out = fwd_q_s;
      end else if (byp_hit_s) begin
         v_out = byp_v_s;
         q_out = TAG_W'(NON_DEPENDENT);
      end else begin
         v_out = v_cur;
         q_out = q_cur;
      end
   end

endmodule

// File: rtl/rename_regfile.sv
// Architectural value/tag arrays with multi-slot rename, multi-port commit and mispredict flush.
// busy_count tracks the number of renamed registers in step with the tag array.
module rename_regfile
   import rename_regfile_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_NUM    = REG_NUM_DEF,
   parameter int RS_W       = $clog2(REG_NUM) + 1,
   parameter int RD_W       = $clog2(REG_NUM),
   parameter int TAG_W      = TAG_W_DEF,
   parameter int DISPATCH_W = DISPATCH_W_DEF,
   parameter int COMMIT_W   = COMMIT_W_DEF
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rdy,
   input  logic [DISPATCH_W-1:0]       dsp_en,
   input  logic [DISPATCH_W*RS_W-1:0]  rs1_from_dsp,
   input  logic [DISPATCH_W*RS_W-1:0]  rs2_from_dsp,
   input  logic [DISPATCH_W*RD_W-1:0]  rd_from_dsp,
   input  logic [DISPATCH_W*TAG_W-1:0] Q_from_dsp,
   output logic [DISPATCH_W*XLEN-1:0]  Vj_to_dsp,
   output logic [DISPATCH_W*XLEN-1:0]  Vk_to_dsp,
   output logic [DISPATCH_W*TAG_W-1:0] Qj_to_dsp,
   output logic [DISPATCH_W*TAG_W-1:0] Qk_to_dsp,
   input  logic [COMMIT_W-1:0]         rob_en,
   input  logic [COMMIT_W*RD_W-1:0]    rd_from_rob,
   input  logic [COMMIT_W*TAG_W-1:0]   Q_from_rob,
   input  logic [COMMIT_W*XLEN-1:0]    V_from_rob,
   input  logic                        mispredict,
   output logic [RD_W:0]               busy_count
);

   logic [XLEN-1:0]  v_r     [REG_NUM];
   logic [TAG_W-1:0] q_r     [REG_NUM];
   logic [RD_W:0]    busy_count_r;
   logic [XLEN-1:0]  v_nxt_s [REG_NUM];
   logic [TAG_W-1:0] q_nxt_s [REG_NUM];
   logic [RD_W:0]    busy_nxt_s;

   // Next-state arrays: commits write V and clear matching tags, then renames override the tag.
   always_comb begin
      busy_nxt_s = '0;
      for (int r = 0; r < REG_NUM; r++) begin
         v_nxt_s[r] = v_r[r];
         q_nxt_s[r] = q_r[r];
         if (r != 0) begin
            for (int c = 0; c < COMMIT_W; c++) begin
               if (rob_en[c] && (rd_from_rob[c*RD_W +: RD_W] == RD_W'(r))) begin
                  v_nxt_s[r] = V_from_rob[c*XLEN +: XLEN];
                  if (Q_from_rob[c*TAG_W +: TAG_W] == q_r[r]) begin
                     q_nxt_s[r] = TAG_W'(NON_DEPENDENT);
                  end else begin
                     q_nxt_s[r] = q_nxt_s[r];
                  end
               end else begin
                  v_nxt_s[r] = v_nxt_s[r];
               end
            end
            if (mispredict) begin
               q_nxt_s[r] = TAG_W'(NON_DEPENDENT);
            end else begin
               for (int d = 0; d < DISPATCH_W; d++) begin
                  if (dsp_en[d] && (rd_from_dsp[d*RD_W +: RD_W] == RD_W'(r))) begin
                     q_nxt_s[r] = Q_from_dsp[d*TAG_W +: TAG_W];
                  end else begin
                     q_nxt_s[r] = q_nxt_s[r];
                  end
               end
            end
         end else begin
            q_nxt_s[r] = TAG_W'(NON_DEPENDENT);
         end
         busy_nxt_s = busy_nxt_s + ((q_nxt_s[r] != TAG_W'(NON_DEPENDENT)) ? (RD_W+1)'(1'b1) : (RD_W+1)'(1'b0));
      end
   end

   // State registers; reset dominates rdy, which gates every update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < REG_NUM; r++) begin
            v_r[r] <= '0;
            q_r[r] <= TAG_W'(NON_DEPENDENT);
         end
         busy_count_r <= '0;
      end else if (rdy) begin
         for (int r = 0; r < REG_NUM; r++) begin
            v_r[r] <= v_nxt_s[r];
            q_r[r] <= q_nxt_s[r];
         end
         busy_count_r <= busy_nxt_s;
      end
   end

   assign busy_count = busy_count_r;

   for (genvar d = 0; d < DISPATCH_W; d++) begin : g_slot
      logic [RS_W-1:0]  rs1_s, rs2_s;
      logic [TAG_W-1:0] qj_cur_s, qk_cur_s;
      logic [XLEN-1:0]  vj_cur_s, vk_cur_s;

      assign rs1_s    = rs1_from_dsp[d*RS_W +: RS_W];
      assign rs2_s    = rs2_from_dsp[d*RS_W +: RS_W];
      assign qj_cur_s = (rs1_s < RS_W'(REG_NUM)) ? q_r[rs1_s[RD_W-1:0]] : TAG_W'(NON_DEPENDENT);
      assign vj_cur_s = (rs1_s < RS_W'(REG_NUM)) ? v_r[rs1_s[RD_W-1:0]] : '0;
      assign qk_cur_s = (rs2_s < RS_W'(REG_NUM)) ? q_r[rs2_s[RD_W-1:0]] : TAG_W'(NON_DEPENDENT);
      assign vk_cur_s = (rs2_s < RS_W'(REG_NUM)) ? v_r[rs2_s[RD_W-1:0]] : '0;

      rename_lookup #(
         .XLEN(XLEN), .REG_NUM(REG_NUM), .RS_W(RS_W), .RD_W(RD_W), .TAG_W(TAG_W),
         .DISPATCH_W(DISPATCH_W), .COMMIT_W(COMMIT_W), .SLOT(d)
      ) u_lookup_j (
         .rs(rs1_s), .dsp_en(dsp_en), .rd_from_dsp(rd_from_dsp), .Q_from_dsp(Q_from_dsp),
         .rob_en(rob_en), .rd_from_rob(rd_from_rob), .Q_from_rob(Q_from_rob), .V_from_rob(V_from_rob),
         .q_cur(qj_cur_s), .v_cur(vj_cur_s), .mispredict(mispredict),
         .v_out(Vj_to_dsp[d*XLEN +: XLEN]), .q_out(Qj_to_dsp[d*TAG_W +: TAG_W])
      );

      rename_lookup #(
         .XLEN(XLEN), .REG_NUM(REG_NUM), .RS_W(RS_W), .RD_W(RD_W), .TAG_W(TAG_W),
         .DISPATCH_W(DISPATCH_W), .COMMIT_W(COMMIT_W), .SLOT(d)
      ) u_lookup_k (
         .rs(rs2_s), .dsp_en(dsp_en), .rd_from_dsp(rd_from_dsp), .Q_from_dsp(Q_from_dsp),
         .rob_en(rob_en), .rd_from_rob(rd_from_rob), .Q_from_rob(Q_from_rob), .V_from_rob(V_from_rob),
         .q_cur(qk_cur_s), .v_cur(vk_cur_s), .mispredict(mispredict),
         .v_out(Vk_to_dsp[d*XLEN +: XLEN]), .q_out(Qk_to_dsp[d*TAG_W +: TAG_W])
      );
   end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed scenarios followed by randomized traffic, checked against an array-based model
// that applies the rename/commit/flush priority rules directly.
module tb_rename_regfile;

   localparam int XLEN = 32, REG_NUM = 32, RS_W = 6, RD_W = 5, TAG_W = 4, DW = 2, CW = 2;

   logic                 clk = 1'b0;
   logic                 rst, rdy, mispredict;
   logic [DW-1:0]        dsp_en;
   logic [DW*RS_W-1:0]   rs1, rs2;
   logic [DW*RD_W-1:0]   rdd;
   logic [DW*TAG_W-1:0]  qd;
   logic [DW*XLEN-1:0]   vj, vk;
   logic [DW*TAG_W-1:0]  qj, qk;
   logic [CW-1:0]        rob_en;
   logic [CW*RD_W-1:0]   rdr;
   logic [CW*TAG_W-1:0]  qr;
   logic [CW*XLEN-1:0]   vr;
   logic [RD_W:0]        busy_count;

   logic [XLEN-1:0]  mv [REG_NUM];
   logic [TAG_W-1:0] mq [REG_NUM];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   rename_regfile dut (
      .clk(clk), .rst(rst), .rdy(rdy), .dsp_en(dsp_en),
      .rs1_from_dsp(rs1), .rs2_from_dsp(rs2), .rd_from_dsp(rdd), .Q_from_dsp(qd),
      .Vj_to_dsp(vj), .Vk_to_dsp(vk), .Qj_to_dsp(qj), .Qk_to_dsp(qk),
      .rob_en(rob_en), .rd_from_rob(rdr), .Q_from_rob(qr), .V_from_rob(vr),
      .mispredict(mispredict), .busy_count(busy_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference read: youngest older rename, then youngest matching commit, then array.
   function automatic void model_read(input int slot, input int rs,
                                      output logic [XLEN-1:0] v, output logic [TAG_W-1:0] q);
      v = '0;
      q = '0;
      if (rs == 0 || rs >= REG_NUM) return;
      if (mispredict) begin
         v = mv[rs];
         for (int c = CW - 1; c >= 0; c--)
            if (rob_en[c] && int'(rdr[c*RD_W +: RD_W]) == rs) begin
               v = vr[c*XLEN +: XLEN];
               break;
            end
         return;
      end
      for (int e = slot - 1; e >= 0; e--)
         if (dsp_en[e] && int'(rdd[e*RD_W +: RD_W]) == rs) begin
            q = qd[e*TAG_W +: TAG_W];
            return;
         end
      for (int c = CW - 1; c >= 0; c--)
         if (rob_en[c] && int'(rdr[c*RD_W +: RD_W]) == rs && qr[c*TAG_W +: TAG_W] == mq[rs]) begin
            v = vr[c*XLEN +: XLEN];
            return;
         end
      v = mv[rs];
      q = mq[rs];
   endfunction

   task automatic model_clock();
      logic [XLEN-1:0]  nv [REG_NUM];
      logic [TAG_W-1:0] nq [REG_NUM];
      bit hit;
      if (rst) begin
         for (int r = 0; r < REG_NUM; r++) begin mv[r] = '0; mq[r] = '0; end
      end else if (rdy) begin
         for (int r = 0; r < REG_NUM; r++) begin nv[r] = mv[r]; nq[r] = mq[r]; end
         for (int c = 0; c < CW; c++)
            if (rob_en[c] && rdr[c*RD_W +: RD_W] != 0) nv[rdr[c*RD_W +: RD_W]] = vr[c*XLEN +: XLEN];
         for (int r = 1; r < REG_NUM; r++) begin
            if (mispredict) nq[r] = '0;
            else begin
               hit = 0;
               for (int d = DW - 1; d >= 0; d--)
                  if (dsp_en[d] && int'(rdd[d*RD_W +: RD_W]) == r) begin
                     nq[r] = qd[d*TAG_W +: TAG_W];
                     hit = 1;
                     break;
                  end
               if (!hit)
                  for (int c = 0; c < CW; c++)
                     if (rob_en[c] && int'(rdr[c*RD_W +: RD_W]) == r && qr[c*TAG_W +: TAG_W] == mq[r]) nq[r] = '0;
            end
         end
         for (int r = 0; r < REG_NUM; r++) begin mv[r] = nv[r]; mq[r] = nq[r]; end
      end
   endtask

   task automatic settle();
      logic [XLEN-1:0] ev;
      logic [TAG_W-1:0] eq;
      #1;
      for (int d = 0; d < DW; d++) begin
         model_read(d, int'(rs1[d*RS_W +: RS_W]), ev, eq);
         check_eq($sformatf("Vj%0d", d), vj[d*XLEN +: XLEN], ev);
         check_eq($sformatf("Qj%0d", d), qj[d*TAG_W +: TAG_W], eq);
         model_read(d, int'(rs2[d*RS_W +: RS_W]), ev, eq);
         check_eq($sformatf("Vk%0d", d), vk[d*XLEN +: XLEN], ev);
         check_eq($sformatf("Qk%0d", d), qk[d*TAG_W +: TAG_W], eq);
      end
   endtask

   task automatic tick();
      int n;
      @(posedge clk);
      model_clock();
      #1;
      n = 0;
      for (int r = 0; r < REG_NUM; r++) if (mq[r] != 0) n++;
      check_eq("busy_count", busy_count, n);
   endtask

   task automatic idle();
      rst = 1'b0; rdy = 1'b1; mispredict = 1'b0;
      dsp_en = '0; rs1 = '0; rs2 = '0; rdd = '0; qd = '0;
      rob_en = '0; rdr = '0; qr = '0; vr = '0;
   endtask

   task automatic set_dsp(input int s, input int rd, input int tag);
      dsp_en[s] = 1'b1;
      rdd[s*RD_W +: RD_W] = RD_W'(rd);
      qd[s*TAG_W +: TAG_W] = TAG_W'(tag);
   endtask

   task automatic set_rob(input int p, input int rd, input int tag, input logic [XLEN-1:0] val);
      rob_en[p] = 1'b1;
      rdr[p*RD_W +: RD_W] = RD_W'(rd);
      qr[p*TAG_W +: TAG_W] = TAG_W'(tag);
      vr[p*XLEN +: XLEN] = val;
   endtask

   initial begin
      int b;
      idle();
      rst = 1'b1;
      tick();
      // x0 ignores renames and reads as zero
      idle(); set_dsp(0, 0, 5); settle();
      check_eq("x0_Vj", vj[XLEN-1:0], 0);
      check_eq("x0_Qj", qj[TAG_W-1:0], 0);
      tick();
      idle(); settle(); tick();
      check_eq("x0_busy", busy_count, 0);
      // intra-bundle forwarding
      idle(); set_dsp(0, 3, 4); rs1[RS_W +: RS_W] = 6'd3; settle();
      check_eq("fwd_Qj1", qj[TAG_W +: TAG_W], 4);
      tick();
      idle(); rs1[RS_W-1:0] = 6'd3; settle();
      check_eq("fwd_Q3", qj[TAG_W-1:0], 4);
      check_eq("fwd_busy", busy_count, 1);
      tick();
      // commit bypass
      idle(); set_dsp(0, 5, 7); settle(); tick();
      idle(); set_rob(1, 5, 7, 32'hDEAD_BEEF); rs2[RS_W-1:0] = 6'd5; settle();
      check_eq("byp_Qk", qk[TAG_W-1:0], 0);
      check_eq("byp_Vk", vk[XLEN-1:0], 32'hDEAD_BEEF);
      tick();
      idle(); rs2[RS_W-1:0] = 6'd5; settle();
      check_eq("byp_Q5", qk[TAG_W-1:0], 0);
      check_eq("byp_V5", vk[XLEN-1:0], 32'hDEAD_BEEF);
      tick();
      // stale commit
      idle(); set_dsp(1, 6, 9); settle(); tick();
      b = busy_count;
      idle(); set_rob(0, 6, 2, 32'h11); settle(); tick();
      check_eq("stale_busy", busy_count, b);
      idle(); rs1[RS_W-1:0] = 6'd6; settle();
      check_eq("stale_V6", vj[XLEN-1:0], 32'h11);
      check_eq("stale_Q6", qj[TAG_W-1:0], 9);
      tick();
      // rename beats commit
      idle(); set_dsp(0, 8, 3); settle(); tick();
      idle(); set_rob(0, 8, 3, 32'h55); set_dsp(1, 8, 6); rs1[RS_W-1:0] = 6'd8; settle();
      check_eq("rbc_Qj0", qj[TAG_W-1:0], 0);
      check_eq("rbc_Vj0", vj[XLEN-1:0], 32'h55);
      tick();
      idle(); rs1[RS_W-1:0] = 6'd8; settle();
      check_eq("rbc_Q8", qj[TAG_W-1:0], 6);
      tick();
      // mispredict flush, then rdy low holds state
      idle(); set_dsp(0, 10, 1); set_dsp(1, 2, 1); settle(); tick();
      check_eq("pre_flush_busy", busy_count, 5);
      idle(); mispredict = 1'b1; set_dsp(0, 12, 5); set_rob(0, 2, 1, 32'h22); rs1[RS_W-1:0] = 6'd2; settle();
      check_eq("mp_Qj0", qj[TAG_W-1:0], 0);
      check_eq("mp_Vj0", vj[XLEN-1:0], 32'h22);
      tick();
      check_eq("mp_busy", busy_count, 0);
      idle(); rdy = 1'b0; set_dsp(0, 13, 5); set_rob(1, 2, 3, 32'h33); settle(); tick();
      idle(); rs1[RS_W-1:0] = 6'd13; rs2[RS_W-1:0] = 6'd2; settle();
      check_eq("hold_Q13", qj[TAG_W-1:0], 0);
      check_eq("hold_V2", vk[XLEN-1:0], 32'h22);
      check_eq("hold_busy", busy_count, 0);
      tick();
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         idle();
         for (int d = 0; d < DW; d++) begin
            dsp_en[d] = ($urandom_range(0, 2) != 0);
            rdd[d*RD_W +: RD_W] = RD_W'($urandom_range(0, 9));
            qd[d*TAG_W +: TAG_W] = TAG_W'($urandom_range(1, 15));
            rs1[d*RS_W +: RS_W] = ($urandom_range(0, 10) == 10) ? 6'd32 : RS_W'($urandom_range(0, 9));
            rs2[d*RS_W +: RS_W] = ($urandom_range(0, 10) == 10) ? 6'd32 : RS_W'($urandom_range(0, 9));
         end
         for (int c = 0; c < CW; c++) begin
            int rd;
            rd = $urandom_range(0, 9);
            rob_en[c] = $urandom_range(0, 1);
            rdr[c*RD_W +: RD_W] = RD_W'(rd);
            qr[c*TAG_W +: TAG_W] = ($urandom_range(0, 2) != 0 && mq[rd] != 0) ? mq[rd] : TAG_W'($urandom_range(1, 15));
            vr[c*XLEN +: XLEN] = $urandom;
         end
         mispredict = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 99) == 0);
         settle();
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
